// File: rtl/ch_dac_pkg.sv
// Shared types and constants for the threshold DAC write engine.
// Frame layout is {command byte, 16-bit code}, MSB first.
package ch_dac_pkg;

  localparam int DAC_FRAME_BITS = 24;
  localparam logic [7:0] DAC_CMD_WRITE_UPDATE = 8'h30;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT_HI,
    S_SHIFT_LO,
    S_TRAIL,
    S_SETTLE
  } dac_wr_state_t;

endpackage

// File: rtl/ch_dac_phase_cnt.sv
// Loadable down-counter; tc_o is high in the last cycle of a loaded span.
// A load of N gives a span of N cycles, then the counter idles at zero.
module ch_dac_phase_cnt #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         arst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == W'(1));

endmodule

// File: rtl/ch_dac_spi_wr.sv
// Threshold DAC write engine: serializes {CMD, code} over SPI, waits for
// the DAC to settle, then pulses ready; one write may queue while busy.
module ch_dac_spi_wr
  import ch_dac_pkg::*;
#(
  parameter int         CLK_DIV       = 4,
  parameter int         SETTLE_CYCLES = 64,
  parameter logic [7:0] CMD           = DAC_CMD_WRITE_UPDATE,
  parameter int         FRAME_BITS    = DAC_FRAME_BITS
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic [15:0] threshold_i,
  input  logic        threshold_wre_i,
  output logic        threshold_rdy_o,
  output logic        busy_o,
  output logic [15:0] dac_code_o,
  output logic        dac_cs_n_o,
  output logic        dac_sclk_o,
  output logic        dac_mosi_o
);

  localparam int PW = $clog2(CLK_DIV + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("CLK_DIV must be at least 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end
  if (FRAME_BITS != DAC_FRAME_BITS) begin : g_bad_frame
    $error("FRAME_BITS must be 24");
  end

  dac_wr_state_t state_q, state_d;
  logic [DAC_FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] frame_q, frame_d;
  logic        pend_q, pend_d;
  logic [15:0] pcode_q, pcode_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;
  logic [15:0] code_q, code_d;

  logic ph_load, ph_tc;
  logic st_load, st_tc;
  logic on_wire;

  ch_dac_phase_cnt #(.W(PW)) u_phase (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .load_i     (ph_load),
    .load_val_i (PW'(CLK_DIV)),
    .tc_o       (ph_tc)
  );

  ch_dac_phase_cnt #(.W(SW)) u_settle (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .load_i     (st_load),
    .load_val_i (SW'(SETTLE_CYCLES)),
    .tc_o       (st_tc)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    pend_d  = pend_q;
    pcode_d = pcode_q;
    rdy_d   = 1'b0;
    code_d  = code_q;

    if (threshold_wre_i && state_q != S_IDLE) begin
      pend_d  = 1'b1;
      pcode_d = threshold_i;
    end

    unique case (state_q)
      S_IDLE: begin
        if (threshold_wre_i || pend_q) begin
          frame_d = threshold_wre_i ? threshold_i : pcode_q;
          shreg_d = {CMD, frame_d};
          bit_d   = '0;
          pend_d  = 1'b0;
          state_d = S_LEAD;
        end
      end
      S_LEAD: begin
        if (ph_tc) state_d = S_SHIFT_HI;
      end
      S_SHIFT_HI: begin
        if (ph_tc) state_d = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        if (ph_tc) begin
          if (bit_q == 5'(FRAME_BITS - 1)) begin
            state_d = S_TRAIL;
          end else begin
            state_d = S_SHIFT_HI;
            bit_d   = bit_q + 5'd1;
            shreg_d = {shreg_q[DAC_FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      S_TRAIL: begin
        if (ph_tc) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (st_tc) begin
          state_d = S_IDLE;
          rdy_d   = 1'b1;
          code_d  = frame_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every pin is a flop.
  always_comb begin
    ph_load = (state_d != state_q);
    st_load = (state_d == S_SETTLE) && (state_q != S_SETTLE);
    on_wire = (state_d == S_LEAD) || (state_d == S_SHIFT_HI) ||
              (state_d == S_SHIFT_LO) || (state_d == S_TRAIL);
    cs_n_d  = !on_wire;
    sclk_d  = (state_d == S_SHIFT_HI);
    mosi_d  = on_wire && shreg_d[DAC_FRAME_BITS-1];
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      pend_q  <= 1'b0;
      pcode_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      pend_q  <= pend_d;
      pcode_q <= pcode_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      code_q  <= code_d;
    end
  end

  assign threshold_rdy_o = rdy_q;
  assign busy_o          = busy_q;
  assign dac_code_o      = code_q;
  assign dac_cs_n_o      = cs_n_q;
  assign dac_sclk_o      = sclk_q;
  assign dac_mosi_o      = mosi_q;

endmodule

// File: tb/tb_ch_dac_spi_wr.sv
// Bench for ch_dac_spi_wr: two instances (2/8 and 1/1 timing) compared
// every cycle against a frame-timing reference model.
module tb_ch_dac_spi_wr;

  logic clk = 1'b0;
  logic arst_n = 1'b0;

  logic [15:0] thr_a, thr_b;
  logic        wre_a, wre_b;
  logic        rdy_a, busy_a, cs_a, sclk_a, mosi_a;
  logic        rdy_b, busy_b, cs_b, sclk_b, mosi_b;
  logic [15:0] code_a, code_b;

  always #5 clk = ~clk;

  ch_dac_spi_wr #(.CLK_DIV(2), .SETTLE_CYCLES(8)) u_a (
    .clk_i(clk), .arst_i(arst_n),
    .threshold_i(thr_a), .threshold_wre_i(wre_a),
    .threshold_rdy_o(rdy_a), .busy_o(busy_a), .dac_code_o(code_a),
    .dac_cs_n_o(cs_a), .dac_sclk_o(sclk_a), .dac_mosi_o(mosi_a)
  );

  ch_dac_spi_wr #(.CLK_DIV(1), .SETTLE_CYCLES(1)) u_b (
    .clk_i(clk), .arst_i(arst_n),
    .threshold_i(thr_b), .threshold_wre_i(wre_b),
    .threshold_rdy_o(rdy_b), .busy_o(busy_b), .dac_code_o(code_b),
    .dac_cs_n_o(cs_b), .dac_sclk_o(sclk_b), .dac_mosi_o(mosi_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: one active frame plus a one-deep pending slot
  bit          m_act [2];
  int          m_start [2];
  logic [15:0] m_code [2];
  bit          m_pend [2];
  logic [15:0] m_pc [2];
  logic [15:0] m_dc [2];

  // observation trackers
  logic        prv_cs [2];
  logic        prv_sc [2];
  logic [23:0] cap [2];
  int          nfall [2];
  logic [23:0] frm [2][8];
  int          nfrm [2];
  int          fall_cyc [2][8];
  int          ncs [2];
  int          rise_cyc [2];
  int          rdy_cnt [2];
  int          rdy_at [2];
  int          bl_cnt [2];
  int          bl_last [2];

  function automatic int cdf(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int stf(input int d);
    return (d == 0) ? 8 : 1;
  endfunction

  function automatic int flen(input int d);
    return cdf(d) * 50;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_pend[d] = 0; m_dc[d] = '0;
      m_start[d] = 0; m_code[d] = '0; m_pc[d] = '0;
    end
  endtask

  task automatic clr(input int d);
    prv_cs[d] = 1'b1; prv_sc[d] = 1'b0; cap[d] = '0;
    nfall[d] = 0; nfrm[d] = 0; ncs[d] = 0; rise_cyc[d] = -1;
    rdy_cnt[d] = 0; rdy_at[d] = -1; bl_cnt[d] = 0; bl_last[d] = -1;
  endtask

  task automatic exp_vals(input int d,
                          output logic cs, sc, mo, bz, rd);
    int o, h;
    logic [23:0] fr;
    cs = 1; sc = 0; mo = 0; bz = 0; rd = 0;
    if (m_act[d]) begin
      o  = cyc - m_start[d];
      fr = {8'h30, m_code[d]};
      if (o >= 0 && o < flen(d)) begin
        cs = 0; bz = 1;
        h  = o / cdf(d);
        if (h == 0) mo = fr[23];
        else if (h <= 48) begin
          sc = (h % 2) == 1;
          mo = fr[23 - (h - 1) / 2];
        end else mo = fr[0];
      end else if (o >= 0 && o < flen(d) + stf(d)) begin
        bz = 1;
      end else if (o == flen(d) + stf(d)) begin
        rd = 1;
      end
    end
  endtask

  task automatic mdl(input int d, input logic w, input logic [15:0] c);
    int r;
    bit idle;
    r = m_start[d] + flen(d) + stf(d);
    idle = !m_act[d] || cyc >= r;
    if (m_act[d] && cyc == r) m_dc[d] = m_code[d];
    if (idle) begin
      if (w) begin
        m_act[d] = 1; m_start[d] = cyc + 1; m_code[d] = c; m_pend[d] = 0;
      end else if (m_pend[d]) begin
        m_act[d] = 1; m_start[d] = cyc + 1; m_code[d] = m_pc[d];
        m_pend[d] = 0;
      end else begin
        m_act[d] = 0;
      end
    end else if (w) begin
      m_pend[d] = 1; m_pc[d] = c;
    end
  endtask

  task automatic scoreboard(input int d, input logic cs, sc, mo, bz, rd,
                            input logic [15:0] dc);
    logic ecs, esc, emo, ebz, erd;
    exp_vals(d, ecs, esc, emo, ebz, erd);
    checks++;
    if (cs !== ecs) begin
      errors++;
      $display("FAIL cs_n dut%0d cyc %0d: got %b want %b", d, cyc, cs, ecs);
    end
    checks++;
    if (sc !== esc) begin
      errors++;
      $display("FAIL sclk dut%0d cyc %0d: got %b want %b", d, cyc, sc, esc);
    end
    checks++;
    if (mo !== emo) begin
      errors++;
      $display("FAIL mosi dut%0d cyc %0d: got %b want %b", d, cyc, mo, emo);
    end
    checks++;
    if (bz !== ebz) begin
      errors++;
      $display("FAIL busy dut%0d cyc %0d: got %b want %b", d, cyc, bz, ebz);
    end
    checks++;
    if (rd !== erd) begin
      errors++;
      $display("FAIL rdy dut%0d cyc %0d: got %b want %b", d, cyc, rd, erd);
    end
    if (!erd) begin
      checks++;
      if (dc !== m_dc[d]) begin
        errors++;
        $display("FAIL dac_code dut%0d cyc %0d: got %h want %h",
                 d, cyc, dc, m_dc[d]);
      end
    end
    if (prv_sc[d] && !sc) begin
      cap[d] = {cap[d][22:0], mo};
      nfall[d]++;
      if (nfall[d] % 24 == 0 && nfrm[d] < 8) begin
        frm[d][nfrm[d]] = cap[d];
        nfrm[d]++;
      end
    end
    if (prv_cs[d] && !cs && ncs[d] < 8) begin
      fall_cyc[d][ncs[d]] = cyc;
      ncs[d]++;
    end
    if (!prv_cs[d] && cs) rise_cyc[d] = cyc;
    if (rd) begin rdy_cnt[d]++; rdy_at[d] = cyc; end
    if (!bz) begin bl_cnt[d]++; bl_last[d] = cyc; end
    prv_cs[d] = cs;
    prv_sc[d] = sc;
  endtask

  task automatic step(input logic wa, input logic [15:0] ca,
                      input logic wb, input logic [15:0] cb);
    wre_a = wa; thr_a = ca; wre_b = wb; thr_b = cb;
    @(negedge clk);
    scoreboard(0, cs_a, sclk_a, mosi_a, busy_a, rdy_a, code_a);
    scoreboard(1, cs_b, sclk_b, mosi_b, busy_b, rdy_b, code_b);
    mdl(0, wa, ca);
    mdl(1, wb, cb);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({cs_a, sclk_a, mosi_a, rdy_a, busy_a} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_pins_a: got %b want 10000",
               {cs_a, sclk_a, mosi_a, rdy_a, busy_a});
    end
    checks++;
    if ({cs_b, sclk_b, mosi_b, rdy_b, busy_b} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_pins_b: got %b want 10000",
               {cs_b, sclk_b, mosi_b, rdy_b, busy_b});
    end
    checks++;
    if (code_a !== 16'h0 || code_b !== 16'h0) begin
      errors++;
      $display("FAIL reset_code: got %h/%h want 0000", code_a, code_b);
    end
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(0, '0, 0, '0);
  endtask

  task automatic test_frame();
    int t0;
    clr(0);
    t0 = cyc;
    step(1, 16'hA5C3, 0, '0);
    for (int i = 1; i <= 115; i++) step(0, '0, 0, '0);
    checks++;
    if (nfrm[0] != 1 || frm[0][0] !== 24'h30A5C3) begin
      errors++;
      $display("FAIL frame_bits: got %0d frames %h want 1 frame 30a5c3",
               nfrm[0], frm[0][0]);
    end
    checks++;
    if (nfall[0] != 24) begin
      errors++;
      $display("FAIL sclk_pulses: got %0d want 24", nfall[0]);
    end
    checks++;
    if (ncs[0] != 1 || fall_cyc[0][0] - t0 != 1 || rise_cyc[0] - t0 != 101) begin
      errors++;
      $display("FAIL cs_window: got %0d..%0d want 1..101",
               fall_cyc[0][0] - t0, rise_cyc[0] - t0);
    end
    checks++;
    if (rdy_cnt[0] != 1 || rdy_at[0] - t0 != 109) begin
      errors++;
      $display("FAIL rdy_timing: got %0d pulses at %0d want 1 at 109",
               rdy_cnt[0], rdy_at[0] - t0);
    end
    checks++;
    if (code_a !== 16'hA5C3) begin
      errors++;
      $display("FAIL code_after: got %h want a5c3", code_a);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    clr(0);
    t0 = cyc;
    for (int i = 0; i <= 240; i++) begin
      if (i == 0) step(1, 16'h0001, 0, '0);
      else if (i == 20) step(1, 16'h0002, 0, '0);
      else if (i == 40) step(1, 16'h0003, 0, '0);
      else step(0, '0, 0, '0);
    end
    checks++;
    if (nfrm[0] != 2 || frm[0][0] !== 24'h300001 || frm[0][1] !== 24'h300003) begin
      errors++;
      $display("FAIL b2b_frames: got %0d frames %h %h want 300001 300003",
               nfrm[0], frm[0][0], frm[0][1]);
    end
    checks++;
    if (ncs[0] != 2 || fall_cyc[0][1] - t0 != 110) begin
      errors++;
      $display("FAIL b2b_start: got %0d want 110", fall_cyc[0][1] - t0);
    end
    checks++;
    if (rdy_cnt[0] != 2) begin
      errors++;
      $display("FAIL b2b_rdy_count: got %0d want 2", rdy_cnt[0]);
    end
  endtask

  task automatic test_write_on_rdy();
    int t0;
    t0 = cyc;
    step(1, 16'h1234, 0, '0);
    clr(0);
    for (int i = 1; i <= 110; i++) begin
      if (i == 109) step(1, 16'hBEEF, 0, '0);
      else step(0, '0, 0, '0);
    end
    checks++;
    if (ncs[0] != 2 || fall_cyc[0][1] - t0 != 110) begin
      errors++;
      $display("FAIL rdy_wre_start: got %0d falls last %0d want cs fall at 110",
               ncs[0], fall_cyc[0][ncs[0] > 0 ? ncs[0] - 1 : 0] - t0);
    end
    checks++;
    if (bl_cnt[0] != 1 || bl_last[0] - t0 != 109) begin
      errors++;
      $display("FAIL rdy_wre_busy: got %0d low cycles last %0d want 1 at 109",
               bl_cnt[0], bl_last[0] - t0);
    end
    for (int i = 0; i < 120; i++) step(0, '0, 0, '0);
    checks++;
    if (code_a !== 16'hBEEF) begin
      errors++;
      $display("FAIL rdy_wre_code: got %h want beef", code_a);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] c;
    step(1, 16'h5A5A, 0, '0);
    for (int i = 1; i < 50; i++) step(0, '0, 0, '0);
    // now mid-cycle 50: assert reset away from any edge
    step(0, '0, 1, 16'h7777);
    arst_n = 1'b0;
    #2;
    checks++;
    if ({cs_a, sclk_a, busy_a, rdy_a} !== 4'b1000) begin
      errors++;
      $display("FAIL async_reset_pins: got %b want 1000",
               {cs_a, sclk_a, busy_a, rdy_a});
    end
    checks++;
    if (code_a !== 16'h0 || cs_b !== 1'b1 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_misc: got code %h cs_b %b busy_b %b want 0000 1 0",
               code_a, cs_b, busy_b);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    clr(0);
    for (int i = 0; i < 150; i++) step(0, '0, 0, '0);
    checks++;
    if (rdy_cnt[0] != 0 || ncs[0] != 0) begin
      errors++;
      $display("FAIL reset_abort: got %0d rdy %0d frames want 0 0",
               rdy_cnt[0], ncs[0]);
    end
    c = 16'($urandom);
    clr(0);
    step(1, c, 0, '0);
    for (int i = 0; i < 115; i++) step(0, '0, 0, '0);
    checks++;
    if (nfrm[0] != 1 || frm[0][0] !== {8'h30, c} || rdy_cnt[0] != 1) begin
      errors++;
      $display("FAIL post_reset_frame: got %h rdy %0d want %h rdy 1",
               frm[0][0], rdy_cnt[0], {8'h30, c});
    end
  endtask

  task automatic test_min_params();
    int t0;
    clr(1);
    t0 = cyc;
    step(0, '0, 1, 16'hFFFF);
    for (int i = 1; i <= 60; i++) step(0, '0, 0, '0);
    checks++;
    if (rdy_cnt[1] != 1 || rdy_at[1] - t0 != 52) begin
      errors++;
      $display("FAIL min_rdy: got %0d pulses at %0d want 1 at 52",
               rdy_cnt[1], rdy_at[1] - t0);
    end
    checks++;
    if (nfall[1] != 24 || frm[1][0] !== 24'h30FFFF) begin
      errors++;
      $display("FAIL min_frame: got %0d falls %h want 24 30ffff",
               nfall[1], frm[1][0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(29) == 0, 16'($urandom),
           $urandom_range(19) == 0, 16'($urandom));
    end
    for (int i = 0; i < 250; i++) step(0, '0, 0, '0);
  endtask

  task automatic test_closed_loop();
    int strobes;
    int rc0;
    bit got;
    logic [15:0] c;
    strobes = 0;
    for (int it = 0; it < 100; it++) begin
      c = 16'($urandom);
      rc0 = rdy_cnt[1];
      step(0, '0, 1, c);
      got = 0;
      for (int k = 0; k < 80 && !got; k++) begin
        step(0, '0, 0, '0);
        if (rdy_cnt[1] != rc0) got = 1;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL loop_timeout it %0d: got no rdy want rdy within 80", it);
      end else begin
        strobes++;
      end
      step(0, '0, 0, '0);
      checks++;
      if (rdy_cnt[1] - rc0 != 1 || code_b !== c) begin
        errors++;
        $display("FAIL loop_iter %0d: got %0d rdy code %h want 1 rdy code %h",
                 it, rdy_cnt[1] - rc0, code_b, c);
      end
    end
    checks++;
    if (strobes != 100) begin
      errors++;
      $display("FAIL loop_strobes: got %0d want 100", strobes);
    end
  endtask

  initial begin
    wre_a = 0; wre_b = 0; thr_a = '0; thr_b = '0;
    model_reset();
    clr(0);
    clr(1);
    test_reset();
    test_frame();
    test_back_to_back();
    test_write_on_rdy();
    test_reset_mid();
    test_min_params();
    test_random();
    clr(1);
    test_closed_loop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ch_dac_spi_wr.md
Name: ch_dac_spi_wr

Overview:
- Threshold DAC write engine. Sits directly upstream of the channel measure controller's DAC handshake.
- Accepts a 16-bit threshold code on a one-cycle write strobe, serializes a 24-bit SPI frame ({CMD, code}, MSB first) to the external threshold DAC, then waits a fixed analog settle time.
- Returns a one-cycle ready pulse. The controller uses this pulse to leave its wait-for-threshold state and request a strobe.

Parameters:
- CLK_DIV, 4: SCLK half-period in clk_i cycles; legal range is 1 or more.
- SETTLE_CYCLES, 64: DAC output settle wait after CS release, in clk_i cycles; legal range is 1 or more.
- CMD, 8'h30: DAC command byte, "write and update channel".
- FRAME_BITS, 24: frame length; fixed at 8 + 16.

Ports:
- clk_i  in  1  system clock
- arst_i  in  1  asynchronous reset, active-low
- threshold_i  in  16  threshold code to write
- threshold_wre_i  in  1  write strobe; code is sampled on the same edge
- threshold_rdy_o  out  1  one-cycle pulse: frame sent and settle time elapsed
- busy_o  out  1  high from the cycle after acceptance until the rdy pulse
- dac_code_o  out  16  last code fully written and settled
- dac_cs_n_o  out  1  SPI chip select, active-low
- dac_sclk_o  out  1  SPI clock, idle low
- dac_mosi_o  out  1  SPI data

Behaviour:
- Clock and reset: one clock, clk_i. Reset arst_i is asynchronous and active-low.
- Reset values:
  - cs_n = 1; sclk = 0; mosi = 0.
  - rdy = 0; busy = 0; dac_code_o = 0.
  - State = IDLE; pending flag cleared.
- All outputs are registered.
- States: IDLE, LEAD, SHIFT_HI, SHIFT_LO, TRAIL, SETTLE.
  - IDLE & wre: load shift register with {CMD, threshold_i}; go to LEAD.
  - LEAD (CLK_DIV cycles):
    - cs_n = 0, sclk = 0.
    - mosi = frame bit 23.
  - SHIFT_HI (CLK_DIV cycles):
    - sclk = 1.
    - On entry, for every bit after the first, mosi advances to the next bit.
  - SHIFT_LO (CLK_DIV cycles):
    - sclk = 0; the DAC samples on this falling edge.
    - After the 24th low phase go to TRAIL; otherwise go back to SHIFT_HI.
  - TRAIL (CLK_DIV cycles): cs_n = 0, sclk = 0.
  - SETTLE (SETTLE_CYCLES cycles): cs_n = 1, mosi = 0.
    - At the end: rdy pulses for 1 cycle; dac_code_o takes the frame code; go to IDLE.
- Latency:
  - Edge that samples wre = cycle 0.
  - cs_n falls in cycle 1.
  - cs_n rises in cycle 1 + CLK_DIV*(2*FRAME_BITS+2).
  - rdy pulses in cycle 1 + CLK_DIV*(2*FRAME_BITS+2) + SETTLE_CYCLES.
- wre while busy:
  - The code is captured into a one-deep pending register. A newer wre overwrites an older pending code.
  - After the rdy pulse, a pending write starts in the next cycle (LEAD).
  - busy_o drops for exactly the rdy cycle.
- wre in the same cycle as the rdy pulse is treated as accepted from IDLE; same timing as a normal start.
- Counters:
  - Bit counter: 5 bits. Phase counter: $clog2(CLK_DIV+1) bits. Settle counter: $clog2(SETTLE_CYCLES+1) bits.
  - All counters are cleared on every state entry. No wrap-around is possible.
- Reset mid-frame: all outputs return to reset values immediately, which aborts the frame with cs_n = 1. The pending write is discarded.
- Elaboration-time assertions: CLK_DIV >= 1, SETTLE_CYCLES >= 1, FRAME_BITS == 24.

Decomposition:
- Package ch_dac_pkg holds:
  - state enum dac_wr_state_t;
  - localparam DAC_FRAME_BITS = 24;
  - DAC_CMD_WRITE_UPDATE = 8'h30.
- One sub-module: ch_dac_phase_cnt. It is a loadable down-counter with a terminal-count pulse, reused for the phase and settle timing.
- Shift register and FSM stay in the top module.

Test Plan:
- Frame content and timing (CLK_DIV=2, SETTLE=8): wre with 16'hA5C3 at cycle 0 ->
  - cs_n low over cycles 1..100, 24 SCLK pulses;
  - bits sampled at falling edges = 24'h30A5C3;
  - rdy single pulse at cycle 109; dac_code_o = A5C3 from cycle 110.
- Back-to-back writes: wre 16'h0001 at cycle 0, wre 16'h0002 at cycle 20, wre 16'h0003 at cycle 40 ->
  - first frame carries 0001;
  - second frame, starting cycle 110, carries 0003;
  - exactly 2 rdy pulses.
- Write on the rdy cycle: wre issued in cycle 109 -> cs_n falls in cycle 110; busy_o is low only in cycle 109.
- Reset mid-frame: arst_i low in cycle 50 ->
  - cs_n = 1, sclk = 0, busy = 0 asynchronously;
  - no rdy pulse; dac_code_o = 0.
  - After release, a wre runs a clean full frame.
- Minimum parameters (CLK_DIV=1, SETTLE=1): wre with 16'hFFFF -> rdy at cycle 52; 24 falling-edge samples = 24'h30FFFF.
- Closed loop with the measure controller model: run_i = 1 -> each threshold_wre yields exactly one rdy, and the controller proceeds to strobe request with no lock-up over 100 iterations.
